// File: rtl/mbm_pkg.sv
// Shared definitions for the log-multiplier datapath: widths and the mantissa field layout.
package mbm_pkg;

  function automatic int k_width(input int n);
    return $clog2(2 * n - 1);
  endfunction

  localparam int MBM_N  = 8;
  localparam int PROD_W = 2 * MBM_N;
  localparam int K_MAX  = 2 * MBM_N - 2;

  // Mantissa is N+1 bits: integer part [N:N-1], fraction [N-2:0].
  localparam int MANT_INT_HI  = MBM_N;
  localparam int MANT_INT_LO  = MBM_N - 1;
  localparam int MANT_FRAC_HI = MBM_N - 2;

endpackage

// File: rtl/antilog_shift_stage_if.sv
// Upstream and downstream valid/ready handshake bundle of the antilog shift stage.
interface antilog_shift_stage_if
  import mbm_pkg::*;
#(
  parameter int N   = MBM_N,
  parameter int K_W = k_width(N)
);
  logic           in_valid;
  logic           in_ready;
  logic [N:0]     mantissa;
  logic           c0;
  logic [K_W-1:0] k_sum;
  logic           zero_op;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;

  modport slave (
    input  in_valid, mantissa, c0, k_sum, zero_op, out_ready,
    output in_ready, out_valid, product
  );

  modport master (
    output in_valid, mantissa, c0, k_sum, zero_op, out_ready,
    input  in_ready, out_valid, product
  );
endinterface

// File: rtl/antilog_barrel_shift.sv
// Combinational antilog: mantissa * 2^k_sum with the fraction bits truncated away.
module antilog_barrel_shift
  import mbm_pkg::*;
#(
  parameter int N   = MBM_N,
  parameter int K_W = k_width(N)
) (
  input  logic [N:0]     mantissa,
  input  logic [K_W-1:0] k_sum,
  output logic [2*N-1:0] product,
  output logic           out_of_range
);
  localparam int WIDE_W = 3 * N - 1;
  localparam int KMAX   = 2 * N - 2;

  always_comb begin
    // Take bits [3N-2:N-1] of the widened shift: drops the N-1 fraction bits.
    product      = (2*N)'((WIDE_W'(mantissa) << k_sum) >> (N - 1));
    out_of_range = int'(k_sum) > KMAX;
  end
endmodule

// File: rtl/antilog_shift_stage.sv
// Two-stage elastic antilog stage: register inputs, then shift/saturate into the product register.
module antilog_shift_stage
  import mbm_pkg::*;
#(
  parameter int N   = MBM_N,
  parameter int K_W = k_width(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  antilog_shift_stage_if.slave  bus,
  output logic                  err,
  input  logic                  clr_err
);
  logic           s1_valid;
  logic [N:0]     s1_mant;
  logic           s1_c0;
  logic [K_W-1:0] s1_k;
  logic           s1_zero;

  logic           s2_valid;
  logic [2*N-1:0] product_q;

  logic           adv1;
  logic           adv2;
  logic [2*N-1:0] shifted;
  logic           oor;
  logic [2*N-1:0] result;
  logic           txn_err;
  logic           load_err;

  antilog_barrel_shift #(.N(N), .K_W(K_W)) u_shift (
    .mantissa     (s1_mant),
    .k_sum        (s1_k),
    .product      (shifted),
    .out_of_range (oor)
  );

  always_comb begin
    adv2 = !s2_valid || bus.out_ready;
    adv1 = !s1_valid || adv2;
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = s2_valid;
  assign bus.product   = product_q;

  // zero_op wins over saturation and suppresses every error source.
  always_comb begin
    result  = shifted;
    txn_err = 1'b0;
    if (s1_zero) begin
      result = '0;
    end else begin
      if (oor) result = '1;
      txn_err = oor || (s1_c0 != s1_mant[N]);
    end
    load_err = adv2 && s1_valid && txn_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mant   <= '0;
      s1_c0     <= 1'b0;
      s1_k      <= '0;
      s1_zero   <= 1'b0;
      s2_valid  <= 1'b0;
      product_q <= '0;
      err       <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= bus.in_valid;
        s1_mant  <= bus.mantissa;
        s1_c0    <= bus.c0;
        s1_k     <= bus.k_sum;
        s1_zero  <= bus.zero_op;
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) product_q <= result;
      end
      if (load_err)     err <= 1'b1;
      else if (clr_err) err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_antilog_shift_stage.sv
// Directed and randomized checks of antilog_shift_stage against an arithmetic reference model.
module tb_antilog_shift_stage;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  logic err;
  logic clr_err;

  antilog_shift_stage_if #(.N(N)) bus ();

  antilog_shift_stage #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err     (err),
    .clr_err (clr_err)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] q[$];
  bit any_err;
  bit rand_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Product = floor(value * 2^k), value = m / 2^(N-1); saturate beyond k = 2N-2.
  function automatic logic [15:0] model(input logic [8:0] m, input logic [3:0] k, input logic z);
    longint p;
    if (z) return 16'd0;
    if (k > 4'd14) return 16'hFFFF;
    p = (longint'(m) * (longint'(1) << k)) / 128;
    return 16'(p);
  endfunction

  task automatic push(input logic [8:0] m, input logic c, input logic [3:0] k, input logic z);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.mantissa = m;
    bus.c0       = c;
    bus.k_sum    = k;
    bus.zero_op  = z;
    #1;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard: samples each cycle the transfers that the next rising edge will perform.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, (q.size() < 2) || bus.out_ready});
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) check("spurious_out", {31'd0, bus.out_valid}, 32'd0);
          else check("product", {16'd0, bus.product}, {16'd0, q.pop_front()});
        end
        if (bus.in_valid && bus.in_ready) begin
          q.push_back(model(bus.mantissa, bus.k_sum, bus.zero_op));
          if (!bus.zero_op && (bus.k_sum > 4'd14 || bus.c0 != bus.mantissa[8])) any_err = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] rm;
    logic       rc;
    logic [3:0] rk;
    logic       rz;
    int         n;

    rst = 1'b1; clr_err = 1'b0; rand_ready = 1'b0; any_err = 1'b0;
    bus.in_valid = 1'b0; bus.mantissa = '0; bus.c0 = 1'b0; bus.k_sum = '0;
    bus.zero_op = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_product", {16'd0, bus.product}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // 1.5 << 3 = 12, two cycles after the transfer
    push(9'b011000000, 1'b0, 4'd3, 1'b0);
    bus.in_valid = 1'b0;
    check("lat_early", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid", {31'd0, bus.out_valid}, 32'd1);
    check("lat_product", {16'd0, bus.product}, 32'd12);
    check("lat_err", {31'd0, err}, 32'd0);

    push(9'b011000000, 1'b0, 4'd0, 1'b0);
    push(9'b101111111, 1'b1, 4'd14, 1'b0);
    bus.in_valid = 1'b0;
    check("trunc_product", {16'd0, bus.product}, 32'd1);
    @(negedge clk);
    check("kmax_product", {16'd0, bus.product}, 32'd49024);
    check("kmax_err", {31'd0, err}, 32'd0);

    push(9'b010000000, 1'b1, 4'd15, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("zero_product", {16'd0, bus.product}, 32'd0);
    check("zero_err", {31'd0, err}, 32'd0);

    push(9'b010000000, 1'b0, 4'd15, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("sat_product", {16'd0, bus.product}, 32'h0000FFFF);
    check("sat_err", {31'd0, err}, 32'd1);

    push(9'b010000000, 1'b0, 4'd15, 1'b0);
    bus.in_valid = 1'b0;
    clr_err = 1'b1;
    @(negedge clk);
    check("err_set_wins", {31'd0, err}, 32'd1);
    @(negedge clk);
    check("err_cleared", {31'd0, err}, 32'd0);
    clr_err = 1'b0;

    // backpressure: two held, third stalls, then drain in order
    bus.out_ready = 1'b0;
    push(9'b010000000, 1'b0, 4'd1, 1'b0);
    push(9'b010000000, 1'b0, 4'd2, 1'b0);
    bus.k_sum = 4'd3;
    #1;
    check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("bp_hold_product", {16'd0, bus.product}, 32'd2);
    @(negedge clk);
    @(negedge clk);
    check("bp_still_held", {16'd0, bus.product}, 32'd2);
    bus.out_ready = 1'b1;
    push(9'b010000000, 1'b0, 4'd3, 1'b0);
    check("bp_second", {16'd0, bus.product}, 32'd4);
    push(9'b010000000, 1'b0, 4'd4, 1'b0);
    bus.in_valid = 1'b0;
    check("bp_third", {16'd0, bus.product}, 32'd8);
    @(negedge clk);
    check("bp_fourth", {16'd0, bus.product}, 32'd16);
    check("bp_fourth_valid", {31'd0, bus.out_valid}, 32'd1);
    @(negedge clk);
    check("bp_empty", {31'd0, bus.out_valid}, 32'd0);

    // reset with two transactions in flight
    push(9'b010000000, 1'b0, 4'd15, 1'b0);
    push(9'b010000000, 1'b0, 4'd6, 1'b0);
    bus.in_valid = 1'b0;
    check("pre_rst_err", {31'd0, err}, 32'd1);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_product", {16'd0, bus.product}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("no_stale", {31'd0, bus.out_valid}, 32'd0);
    end

    any_err = 1'b0;
    rand_ready = 1'b1;
    for (int unsigned i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      rm = {2'($urandom_range(0, 2)), 7'($urandom)};
      rc = ($urandom_range(0, 7) == 0) ? !rm[8] : rm[8];
      rk = 4'($urandom_range(0, 15));
      rz = ($urandom_range(0, 7) == 0);
      push(rm, rc, rk, rz);
    end
    bus.in_valid = 1'b0;
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", q.size(), 32'd0);
    repeat (2) @(negedge clk);
    check("rand_err", {31'd0, err}, {31'd0, any_err});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/antilog_shift_stage.md
Name: antilog_shift_stage

Overview:
- Downstream of the error-coefficient adder in the log-multiplier datapath. Consumes the corrected mantissa plus the characteristic sum (k1+k2) and produces the final integer product mantissa*2^k, truncated as in Mitchell/MBM.
- Two-stage elastic pipeline with valid/ready handshakes on both sides, a zero-operand bypass, and a sticky error flag for out-of-range characteristics or a c0/mantissa mismatch.

Parameters:
- N, 8, operand width; mantissa is N+1 bits with N-1 fractional bits.
- K_W, $clog2(2*N-1), width of characteristic sum (4 for N=8).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream transaction valid
- in_ready  out  1  stage can accept this cycle
- mantissa  in  N+1  {int[1:0], frac[N-2:0]} from error-coefficient adder
- c0  in  1  mantissa>=2 indicator; must equal mantissa[N]
- k_sum  in  K_W  characteristic sum k1+k2
- zero_op  in  1  either multiplier operand was zero
- out_valid  out  1  product valid
- out_ready  in  1  downstream accepts product
- product  out  2N  final product
- err  out  1  sticky error flag
- clr_err  in  1  clears err

Behaviour:
- Reset (synchronous, active-high): s1_valid=0, s2_valid=0, out_valid=0, product=0, err=0, in_ready=1 on the cycle after reset releases. Reset mid-operation drops all in-flight transactions; no output is produced for them.
- Handshake: a transfer occurs on a cycle when valid&&ready is high. Data must be held stable while valid is high and ready is low. out_valid never drops without a transfer.
- Advance rules:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1, combinational; no combinational path from in_valid to in_ready.
- Stage 1 (register): on adv1, captures mantissa, c0, k_sum, zero_op and sets s1_valid=in_valid.
- Stage 2 (shift, register): on adv2, s2_valid<=s1_valid. When s1_valid, product is computed as follows:
  - zero_op=1 -> 0.
  - k_sum>2N-2 -> {2N{1'b1}} (saturate), and err is set.
  - otherwise -> bits [3N-2:N-1] of (mantissa << k_sum) in a 3N-1 bit intermediate. This is truncation toward zero; no rounding.
- zero_op takes priority over range saturation; a zero_op transaction never sets err.
- c0 != mantissa[N] on a captured transaction (zero_op=0) sets err. The shift still uses mantissa as given.
- Latency: 2 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 per cycle.
- Backpressure: with out_ready low, the pipeline holds at most 2 transactions, then in_ready drops. Ordering is preserved; no loss or duplication.
- err: set in stage 2 when an erroring transaction is loaded. clr_err clears it. If set and clear occur in the same cycle, set wins. err is independent of the handshake.
- Width proof: the maximum mantissa is <3.0 and k_max=2N-2, so every in-range result is <3*2^(2N-2), which is <2^(2N). No overflow is possible.

Decomposition:
- Shared package mbm_pkg:
  - function k_width(N)
  - localparams PROD_W=2*N, K_MAX=2*N-2
  - the mantissa field layout (integer bits [N:N-1], fraction [N-2:0])
- One combinational sub-module antilog_barrel_shift (mantissa, k_sum -> product, out_of_range). It is instantiated in stage 2 and reusable by the upstream log-encoder tests.

Test Plan (N=8):
- mantissa=9'b011000000 (1.5), c0=0, k_sum=3, out_ready=1 -> product=12 exactly 2 cycles after the transfer; err=0.
- mantissa=9'b011000000, k_sum=0 -> product=1 (truncation). mantissa=9'b101111111, c0=1, k_sum=14 -> product=49024.
- zero_op=1 with k_sum=15 and c0 mismatched -> product=0; err stays 0.
- k_sum=15, mantissa=9'b010000000 -> product=16'hFFFF, err=1. Same cycle as clr_err=1 with another k_sum=15 still in stage 2: err remains 1. A later clr_err alone clears it.
- Backpressure: stream 4 back-to-back inputs (k=1,2,3,4 on 1.0) with out_ready=0 for 4 cycles. Expect in_ready=0 after 2 accepts. Releasing out_ready yields 2,4,8,16 in order with no gaps beyond one per cycle.
- Assert rst while 2 transactions are in flight -> next cycle out_valid=0, product=0, err=0. No stale product emerges after rst deasserts.
